t_mem_result_unloader: RTL and testbench

//  Downstream drain stage of the ModExp2 datapath. After exponentiation, walks the
//  t_mem result buffer word by word (LSW first) and streams the words out over a

---
 rtl/t_mem_result_unloader.sv | 110 +++++++++++
 tb/tb_t_mem_result_unloader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/t_mem_result_unloader.sv
// Drain stage for the ModExp2 t_mem result buffer: reads NUM_WORDS words LSW first
// and streams them over valid/ready, with a 2-entry skid buffer covering read latency.
module t_mem_result_unloader #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WORDS  = 128
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_rden,
    output logic [ADDR_WIDTH-1:0] mem_address,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic [1:0]            dbg_state
);
    // Handshake: a word transfers in every cycle where out_valid & out_ready are both
    // high; out_data/out_valid never change while out_valid is high and out_ready low.

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);
    localparam logic [ADDR_WIDTH:0]   LAST_IDX  = (ADDR_WIDTH + 1)'(NUM_WORDS - 1);

    logic [1:0]            state;
    logic [1:0]            credits;
    logic                  rd_pending;
    logic [DATA_WIDTH-1:0] buf0;
    logic [DATA_WIDTH-1:0] buf1;
    logic                  wr_sel;
    logic                  rd_sel;
    logic [1:0]            count;
    logic [ADDR_WIDTH:0]   out_idx;
    logic                  pop;
    logic                  push;
    logic                  issue;

    assign pop       = out_valid & out_ready;
    assign push      = rd_pending;
    // credits >= 1 whenever pop is high, so the subtraction cannot underflow
    assign issue     = (state == S_READ) && ((credits - {1'b0, pop}) < 2'd2);
    assign mem_rden  = issue;
    assign out_valid = (count != 2'd0);
    assign out_data  = rd_sel ? buf1 : buf0;
    assign out_last  = out_valid && (out_idx == LAST_IDX);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign dbg_state = state;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            mem_address <= '0;
            credits     <= 2'd0;
            out_idx     <= '0;
        end else begin
            credits <= credits + {1'b0, issue} - {1'b0, pop};
            if (pop) out_idx <= out_idx + 1'b1;
            // mem_address doubles as the read pointer; it parks on the last address
            if (issue && mem_address != LAST_ADDR) mem_address <= mem_address + 1'b1;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state       <= S_READ;
                        mem_address <= '0;
                        credits     <= 2'd0;
                        out_idx     <= '0;
                    end
                end
                S_READ:  if (issue && mem_address == LAST_ADDR) state <= S_DRAIN;
                S_DRAIN: if (pop && out_last) state <= S_DONE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_pending <= 1'b0;
            buf0       <= '0;
            buf1       <= '0;
            wr_sel     <= 1'b0;
            rd_sel     <= 1'b0;
            count      <= 2'd0;
        end else begin
            rd_pending <= issue;
            if (push) begin
                if (wr_sel) buf1 <= mem_q;
                else        buf0 <= mem_q;
                wr_sel <= ~wr_sel;
            end
            if (pop) rd_sel <= ~rd_sel;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    a_no_overflow: assert property (@(posedge clock) disable iff (reset)
        !(push && !pop && count == 2'd2));
    a_credit_range: assert property (@(posedge clock) disable iff (reset)
        credits <= 2'd2);

endmodule

// File: tb/tb_t_mem_result_unloader.sv
// Scoreboard bench for t_mem_result_unloader: a 128-word build and a 1-word build,
// each fed by a synchronous t_mem model.
module tb_t_mem_result_unloader;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        out_ready = 1'b0;
    logic        busy, done, mem_rden, out_valid, out_last;
    logic [6:0]  mem_address;
    logic [31:0] mem_q = '0;
    logic [31:0] out_data;
    logic [1:0]  dbg_state;

    logic        start_s = 1'b0;
    logic        ready_s = 1'b1;
    logic        busy_s, done_s, rden_s, valid_s, last_s;
    logic [0:0]  addr_s;
    logic [31:0] q_s = '0;
    logic [31:0] data_s;
    logic [1:0]  state_s;

    int total = 0;
    int bad = 0;
    int rd_exp = 0;
    int outstanding = 0;
    int pop_cnt = 0;
    int pop_base = 0;
    int seed_val;
    logic [32:0] exp_q[$];
    logic [32:0] exp_s[$];

    t_mem_result_unloader #(.ADDR_WIDTH(7), .DATA_WIDTH(32), .NUM_WORDS(128)) u_big (
        .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
        .mem_rden(mem_rden), .mem_address(mem_address), .mem_q(mem_q),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .dbg_state(dbg_state)
    );

    t_mem_result_unloader #(.ADDR_WIDTH(1), .DATA_WIDTH(32), .NUM_WORDS(1)) u_small (
        .clock(clock), .reset(reset), .start(start_s), .busy(busy_s), .done(done_s),
        .mem_rden(rden_s), .mem_address(addr_s), .mem_q(q_s),
        .out_data(data_s), .out_valid(valid_s), .out_ready(ready_s),
        .out_last(last_s), .dbg_state(state_s)
    );

    // clock/reset block
    always #5 clock = ~clock;

    // synchronous t_mem models
    always @(posedge clock) if (mem_rden) mem_q <= 32'(mem_address) * 32'd3;
    always @(posedge clock) if (rden_s) q_s <= 32'(addr_s) * 32'd3 + 32'd5;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // scoreboard monitor, 128-word build
    always @(negedge clock) begin
        if (!reset) begin
            if (mem_rden) begin
                chk("rd_addr", 64'(mem_address), 64'(rd_exp));
                rd_exp++;
                outstanding++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL out_word unexpected actual=%0h required=none", {out_last, out_data});
                end else begin
                    chk("out_word", 64'({out_last, out_data}), 64'(exp_q.pop_front()));
                end
                pop_cnt++;
                outstanding--;
            end
            chk("credits_le2", 64'(outstanding <= 2), 64'd1);
        end
    end

    // scoreboard monitor, 1-word build
    always @(negedge clock) begin
        if (!reset && valid_s && ready_s) begin
            if (exp_s.size() == 0) begin
                total++;
                bad++;
                $display("FAIL small_word unexpected actual=%0h required=none", {last_s, data_s});
            end else begin
                chk("small_word", 64'({last_s, data_s}), 64'(exp_s.pop_front()));
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    // start high in cycle 0; returns at cycle 1
    task automatic start_big();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 128; i++) exp_q.push_back({(i == 127), 32'(i * 3)});
        rd_exp = 0;
        outstanding = 0;
        pop_base = pop_cnt;
    endtask

    task automatic end_transfer(input string name);
        @(negedge clock);
        chk({name, "_busy_low"}, 64'(busy), 64'd0);
        chk({name, "_pops"}, 64'(pop_cnt - pop_base), 64'd128);
        chk({name, "_q_empty"}, 64'(exp_q.size()), 64'd0);
        chk({name, "_reads"}, 64'(rd_exp), 64'd128);
        tick();
    endtask

    // mode 0: ready=1; mode 1: toggle then random stalls; mode 2: ready=1, stray starts
    task automatic run_xfer(input string name, input int mode);
        bit got = 0;
        start_big();
        for (int c = 1; c < 1000 && !got; c++) begin
            if (mode == 1) out_ready = (c < 80) ? (c % 2 == 1) : 1'($urandom_range(0, 1));
            else           out_ready = 1'b1;
            start = (mode == 2) && (c == 5 || c == 60);
            @(negedge clock);
            if (done) got = 1;
            tick();
        end
        start = 1'b0;
        out_ready = 1'b1;
        total++;
        if (!got) begin
            bad++;
            $display("FAIL %s_done_timeout actual=no_done required=done", name);
        end
        end_transfer(name);
    endtask

    initial begin
        bit got;
        int reads;
        seed_val = $urandom(32'd2024);

        // reset values
        #3;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_rden", 64'(mem_rden), 64'd0);
        chk("rst_addr", 64'(mem_address), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_last", 64'(out_last), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // 1: full-rate stream with cycle-exact timing
        out_ready = 1'b1;
        start_big();
        for (int c = 1; c <= 133; c++) begin
            @(negedge clock);
            chk("t1_busy", 64'(busy), 64'(c <= 131));
            chk("t1_done", 64'(done), 64'(c == 131));
            chk("t1_valid", 64'(out_valid), 64'(c >= 3 && c <= 130));
            chk("t1_last", 64'(out_last), 64'(c == 130));
            tick();
        end
        end_transfer("t1");

        // 2: consumer stalled for 20 cycles
        out_ready = 1'b0;
        reads = 0;
        start_big();
        for (int c = 1; c <= 20; c++) begin
            @(negedge clock);
            if (mem_rden) reads++;
            if (c == 20) begin
                chk("t2_reads", 64'(reads), 64'd2);
                chk("t2_valid", 64'(out_valid), 64'd1);
                chk("t2_data", 64'(out_data), 64'd0);
            end
            tick();
        end
        out_ready = 1'b1;
        got = 0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clock);
            if (done) got = 1;
            tick();
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL t2_done_timeout actual=no_done required=done");
        end
        end_transfer("t2");

        // 3 and 4
        run_xfer("t3", 1);
        run_xfer("t4", 2);

        // 5: reset in cycle 40 with a read in flight
        out_ready = 1'b1;
        start_big();
        for (int c = 1; c < 40; c++) tick();
        reset = 1'b1;
        #1;
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_done", 64'(done), 64'd0);
        chk("t5_rden", 64'(mem_rden), 64'd0);
        chk("t5_addr", 64'(mem_address), 64'd0);
        chk("t5_valid", 64'(out_valid), 64'd0);
        chk("t5_last", 64'(out_last), 64'd0);
        chk("t5_data", 64'(out_data), 64'd0);
        exp_q.delete();
        tick();
        reset = 1'b0;
        tick();
        run_xfer("t5", 0);

        // 6: single-word build
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        exp_s.push_back({1'b1, 32'd5});
        for (int c = 1; c <= 6; c++) begin
            @(negedge clock);
            chk("t6_valid", 64'(valid_s), 64'(c == 3));
            chk("t6_last", 64'(last_s), 64'(c == 3));
            chk("t6_done", 64'(done_s), 64'(c == 4));
            chk("t6_busy", 64'(busy_s), 64'(c <= 4));
            tick();
        end
        chk("t6_q_empty", 64'(exp_s.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
